// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: control ops, exception codes,
// control-register addresses and execution-mode values.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      CtrlNop  = 2'd0,
      CtrlWrcr = 2'd1,
      CtrlEret = 2'd2
   } ctrl_op_e;

   typedef enum logic [2:0] {
      ExpNone   = 3'd0,
      ExpExtInt = 3'd1,
      ExpUndef  = 3'd2,
      ExpOvf    = 3'd3,
      ExpMisa   = 3'd4,
      ExpPriv   = 3'd5
   } exp_code_e;

   localparam logic [4:0] CregStatus    = 5'd0;
   localparam logic [4:0] CregPreStatus = 5'd1;
   localparam logic [4:0] CregEpc       = 5'd2;
   localparam logic [4:0] CregExpVector = 5'd3;
   localparam logic [4:0] CregCause     = 5'd4;
   localparam logic [4:0] CregIntMask   = 5'd5;
   localparam logic [4:0] CregIrq       = 5'd6;

   localparam logic ModeKernel = 1'b0;
   localparam logic ModeUser   = 1'b1;

endpackage

// File: rtl/ctrl_creg.sv
// Control-register file of the pipeline controller: STATUS, PRE_STATUS, EPC,
// EXP_VECTOR, CAUSE, INT_MASK and the read-only IRQ view, plus the read mux.
module ctrl_creg #(
   parameter int unsigned IRQ_W  = 8,
   parameter int unsigned ADDR_W = 30,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              exp_commit,
   input  logic              eret_commit,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] exp_epc,
   input  logic [3:0]        exp_cause,
   input  logic [IRQ_W-1:0]  irq_pend,
   input  logic [4:0]        rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              exe_mode,
   output logic              int_en,
   output logic [ADDR_W-1:0] epc,
   output logic [ADDR_W-1:0] exp_vector,
   output logic [IRQ_W-1:0]  int_mask
);
   import pipe_ctrl_pkg::*;

   // status = {int_en, exe_mode}
   logic [1:0]        status_d, status_q;
   logic [1:0]        pre_status_d, pre_status_q;
   logic [ADDR_W-1:0] epc_d, epc_q;
   logic [ADDR_W-1:0] exp_vector_d, exp_vector_q;
   logic [3:0]        cause_d, cause_q;
   logic [IRQ_W-1:0]  int_mask_d, int_mask_q;
   logic              unused_wr_data;

   assign unused_wr_data = ^wr_data;

   always_comb begin
      status_d     = status_q;
      pre_status_d = pre_status_q;
      epc_d        = epc_q;
      exp_vector_d = exp_vector_q;
      cause_d      = cause_q;
      int_mask_d   = int_mask_q;
      if (exp_commit) begin
         pre_status_d = status_q;
         status_d     = {1'b0, ModeKernel};
         epc_d        = exp_epc;
         cause_d      = exp_cause;
      end else if (eret_commit) begin
         status_d = pre_status_q;
      end else if (wr_en) begin
         case (wr_addr)
            CregStatus:    status_d     = wr_data[1:0];
            CregPreStatus: pre_status_d = wr_data[1:0];
            CregEpc:       epc_d        = wr_data[ADDR_W-1:0];
            CregExpVector: exp_vector_d = wr_data[ADDR_W-1:0];
            CregCause:     cause_d      = wr_data[3:0];
            CregIntMask:   int_mask_d   = wr_data[IRQ_W-1:0];
            default:       ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         status_q     <= {1'b0, ModeKernel};
         pre_status_q <= '0;
         epc_q        <= '0;
         exp_vector_q <= '0;
         cause_q      <= '0;
         int_mask_q   <= '1;
      end else begin
         status_q     <= status_d;
         pre_status_q <= pre_status_d;
         epc_q        <= epc_d;
         exp_vector_q <= exp_vector_d;
         cause_q      <= cause_d;
         int_mask_q   <= int_mask_d;
      end
   end

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         CregStatus:    rd_data = DATA_W'(status_q);
         CregPreStatus: rd_data = DATA_W'(pre_status_q);
         CregEpc:       rd_data = DATA_W'(epc_q);
         CregExpVector: rd_data = DATA_W'(exp_vector_q);
         CregCause:     rd_data = DATA_W'(cause_q);
         CregIntMask:   rd_data = DATA_W'(int_mask_q);
         CregIrq:       rd_data = DATA_W'(irq_pend);
         default:       rd_data = '0;
      endcase
   end

   assign exe_mode   = status_q[0];
   assign int_en     = status_q[1];
   assign epc        = epc_q;
   assign exp_vector = exp_vector_q;
   assign int_mask   = int_mask_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush generation and MEM-stage commit of exceptions,
// interrupts (only when PIPE_CTRL_IRQ_EN is defined), ERET and WRCR.
module pipe_ctrl #(
   parameter int unsigned IRQ_W  = 8,
   parameter int unsigned ADDR_W = 30,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_busy,
   input  logic              mem_busy,
   input  logic              ld_hazard,
   input  logic              mem_en,
   input  logic [ADDR_W-1:0] mem_pc,
   input  logic              mem_br_flag,
   input  logic [1:0]        mem_ctrl_op,
   input  logic [4:0]        mem_dst_addr,
   input  logic [DATA_W-1:0] mem_out,
   input  logic [2:0]        mem_exp_code,
   input  logic [IRQ_W-1:0]  irq,
   input  logic [4:0]        creg_rd_addr,
   output logic [DATA_W-1:0] creg_rd_data,
   output logic              exe_mode,
   output logic              if_stall,
   output logic              id_stall,
   output logic              ex_stall,
   output logic              mem_stall,
   output logic              if_flush,
   output logic              id_flush,
   output logic              ex_flush,
   output logic              mem_flush,
   output logic [ADDR_W-1:0] new_pc
);
   import pipe_ctrl_pkg::*;

   logic              stall_all, commit, exp_sync, irq_req, flush;
   logic              exp_commit, eret_commit, wr_en, int_en;
   logic [ADDR_W-1:0] exp_epc, epc, exp_vector;
   logic [3:0]        exp_cause;
   logic [IRQ_W-1:0]  irq_pend, int_mask;

`ifdef PIPE_CTRL_IRQ_EN
   assign irq_pend = irq;
   assign irq_req  = int_en & |(irq & ~int_mask);
`else
   logic unused_irq;
   assign irq_pend   = '0;
   assign irq_req    = 1'b0;
   assign unused_irq = ^{irq, int_mask, int_en};
`endif

   always_comb begin
      stall_all   = if_busy | mem_busy;
      // Reset kills any commit so flushes and new_pc stay low while it is held.
      commit      = mem_en & ~stall_all & ~reset;
      exp_sync    = (mem_exp_code != ExpNone);
      exp_commit  = commit & (exp_sync | irq_req);
      eret_commit = commit & ~exp_sync & ~irq_req & (mem_ctrl_op == CtrlEret);
      wr_en       = commit & ~exp_sync & ~irq_req & (mem_ctrl_op == CtrlWrcr) &
                    (exe_mode == ModeKernel);
      exp_cause   = {mem_br_flag, exp_sync ? mem_exp_code : ExpExtInt};
      exp_epc     = mem_pc - ADDR_W'(mem_br_flag);
      flush       = exp_commit | eret_commit;

      if_stall  = stall_all | ld_hazard;
      id_stall  = stall_all;
      ex_stall  = stall_all;
      mem_stall = stall_all;
      if_flush  = flush;
      id_flush  = flush | (ld_hazard & ~stall_all & ~reset);
      ex_flush  = flush;
      mem_flush = flush;
      new_pc    = '0;
      if (exp_commit) begin
         new_pc = exp_vector;
      end else if (eret_commit) begin
         new_pc = epc;
      end
   end

   ctrl_creg #(
      .IRQ_W  (IRQ_W),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ctrl_creg (
      .clk         (clk),
      .reset       (reset),
      .exp_commit  (exp_commit),
      .eret_commit (eret_commit),
      .wr_en       (wr_en),
      .wr_addr     (mem_dst_addr),
      .wr_data     (mem_out),
      .exp_epc     (exp_epc),
      .exp_cause   (exp_cause),
      .irq_pend    (irq_pend),
      .rd_addr     (creg_rd_addr),
      .rd_data     (creg_rd_data),
      .exe_mode    (exe_mode),
      .int_en      (int_en),
      .epc         (epc),
      .exp_vector  (exp_vector),
      .int_mask    (int_mask)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, all checked
// against an architectural model of the control registers held in the bench.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic        clk, reset, if_busy, mem_busy, ld_hazard, mem_en, mem_br_flag;
   logic [29:0] mem_pc, new_pc;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr, creg_rd_addr;
   logic [31:0] mem_out, creg_rd_data;
   logic [2:0]  mem_exp_code;
   logic [7:0]  irq;
   logic        exe_mode, if_stall, id_stall, ex_stall, mem_stall;
   logic        if_flush, id_flush, ex_flush, mem_flush;

   int n_assert = 0;
   int n_fail   = 0;

   // Architectural model state
   bit        m_int_en, m_mode;
   bit [1:0]  m_pre;
   bit [29:0] m_epc, m_vec;
   bit [3:0]  m_cause;
   bit [7:0]  m_mask;

   pipe_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .if_busy      (if_busy),
      .mem_busy     (mem_busy),
      .ld_hazard    (ld_hazard),
      .mem_en       (mem_en),
      .mem_pc       (mem_pc),
      .mem_br_flag  (mem_br_flag),
      .mem_ctrl_op  (mem_ctrl_op),
      .mem_dst_addr (mem_dst_addr),
      .mem_out      (mem_out),
      .mem_exp_code (mem_exp_code),
      .irq          (irq),
      .creg_rd_addr (creg_rd_addr),
      .creg_rd_data (creg_rd_data),
      .exe_mode     (exe_mode),
      .if_stall     (if_stall),
      .id_stall     (id_stall),
      .ex_stall     (ex_stall),
      .mem_stall    (mem_stall),
      .if_flush     (if_flush),
      .id_flush     (id_flush),
      .ex_flush     (ex_flush),
      .mem_flush    (mem_flush),
      .new_pc       (new_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd0:    return {30'd0, m_int_en, m_mode};
         5'd1:    return {30'd0, m_pre};
         5'd2:    return {2'd0, m_epc};
         5'd3:    return {2'd0, m_vec};
         5'd4:    return {28'd0, m_cause};
         5'd5:    return {24'd0, m_mask};
         5'd6:    return IRQ_ON ? {24'd0, irq} : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      m_int_en = 0; m_mode = 0; m_pre = 0; m_epc = 0; m_vec = 0; m_cause = 0; m_mask = 8'hFF;
   endtask

   task automatic quiet();
      reset = 0; if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 0; mem_br_flag = 0;
      mem_pc = 0; mem_ctrl_op = 0; mem_dst_addr = 0; mem_out = 0; mem_exp_code = 0; irq = 0;
   endtask

   // Called just after a falling edge with inputs applied; checks, clocks, updates model.
   task automatic run_cycle(input string tag);
      bit        sa, cm, sync, ir;
      int        kind;  // 0 none, 1 exception/interrupt, 2 eret, 3 wrcr
      logic [3:0] e_flush;
      logic [29:0] e_pc;
      #1;
      sa   = if_busy || mem_busy;
      cm   = mem_en && !sa && !reset;
      sync = (mem_exp_code != 3'd0);
      ir   = IRQ_ON && m_int_en && ((irq & ~m_mask) != 8'd0);
      if (!cm) kind = 0;
      else if (sync || ir) kind = 1;
      else if (mem_ctrl_op == 2'd2) kind = 2;
      else if (mem_ctrl_op == 2'd1) kind = 3;
      else kind = 0;
      e_flush = (kind == 1 || kind == 2) ? 4'hF : {1'b0, ld_hazard && !sa && !reset, 2'b00};
      e_pc    = (kind == 1) ? m_vec : (kind == 2) ? m_epc : 30'd0;
      check({tag, ".stall"}, {if_stall, id_stall, ex_stall, mem_stall},
            {sa || ld_hazard, sa, sa, sa});
      check({tag, ".flush"}, {if_flush, id_flush, ex_flush, mem_flush}, e_flush);
      check({tag, ".new_pc"}, new_pc, e_pc);
      check({tag, ".mode"}, exe_mode, m_mode);
      check({tag, ".rd"}, creg_rd_data, m_read(creg_rd_addr));
      @(posedge clk);
      if (reset) begin
         m_reset();
      end else if (kind == 1) begin
         m_pre    = {m_int_en, m_mode};
         m_int_en = 0;
         m_mode   = 0;
         m_epc    = 30'((64'(mem_pc) + 64'h4000_0000 - 64'(mem_br_flag)) % 64'h4000_0000);
         m_cause  = {mem_br_flag, sync ? mem_exp_code : 3'd1};
      end else if (kind == 2) begin
         {m_int_en, m_mode} = m_pre;
      end else if (kind == 3 && m_mode == 1'b0) begin
         case (mem_dst_addr)
            5'd0: {m_int_en, m_mode} = mem_out[1:0];
            5'd1: m_pre   = mem_out[1:0];
            5'd2: m_epc   = mem_out[29:0];
            5'd3: m_vec   = mem_out[29:0];
            5'd4: m_cause = mem_out[3:0];
            5'd5: m_mask  = mem_out[7:0];
            default: ;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic wrcr(input logic [4:0] a, input logic [31:0] d, input string tag);
      quiet(); mem_en = 1; mem_ctrl_op = 2'd1; mem_dst_addr = a; mem_out = d;
      run_cycle(tag);
   endtask

   initial begin
      quiet();
      creg_rd_addr = 0;
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      m_reset();
      // Reset held with a would-be commit: no flush, stalls follow inputs
      mem_en = 1; mem_exp_code = 3'd3; mem_busy = 1;
      run_cycle("rst_busy");
      mem_busy = 0;
      #1 check("rst.flush", {if_flush, id_flush, ex_flush, mem_flush}, 4'h0);
      run_cycle("rst_commit");
      quiet();
      creg_rd_addr = 5;
      #1 check("rst.int_mask", creg_rd_data, 32'hFF);
      run_cycle("rst_idle");

      // 1: bus busy plus hazard -> everything held, no bubble
      mem_busy = 1; ld_hazard = 1; mem_en = 1; mem_exp_code = 3'd2;
      #1 check("t1.stall", {if_stall, id_stall, ex_stall, mem_stall}, 4'hF);
      check("t1.id_flush", id_flush, 1'b0);
      run_cycle("t1");
      // 2: load hazard alone -> bubble into ID/EX
      quiet(); ld_hazard = 1;
      #1 check("t2.stall", {if_stall, id_stall, ex_stall, mem_stall}, 4'b1000);
      check("t2.id_flush", id_flush, 1'b1);
      run_cycle("t2");

      // 3: vector write then overflow in a delay slot
      wrcr(5'd3, 32'h100, "t3.wr");
      quiet(); mem_en = 1; mem_exp_code = 3'd3; mem_pc = 30'h40; mem_br_flag = 1;
      #1 check("t3.new_pc", new_pc, 30'h100);
      run_cycle("t3.exp");
      quiet(); creg_rd_addr = 2;
      #1 check("t3.epc", creg_rd_data, 32'h3F);
      run_cycle("t3.epc_rd");
      creg_rd_addr = 4;
      #1 check("t3.cause", creg_rd_data, 32'hB);
      run_cycle("t3.cause_rd");

      // 4: ERET into USER, then a USER write to STATUS is dropped
      wrcr(5'd1, 32'h3, "t4.pre");
      wrcr(5'd2, 32'h80, "t4.epc");
      quiet(); mem_en = 1; mem_ctrl_op = 2'd2;
      #1 check("t4.new_pc", new_pc, 30'h80);
      run_cycle("t4.eret");
      quiet(); creg_rd_addr = 0;
      #1 check("t4.status", creg_rd_data, 32'h3);
      wrcr(5'd0, 32'h0, "t4.user_wr");
      creg_rd_addr = 0;
      #1 check("t4.status_kept", creg_rd_data, 32'h3);

      // EPC wrap when a delay-slot instruction sits at PC 0
      quiet(); mem_en = 1; mem_exp_code = 3'd4; mem_br_flag = 1; creg_rd_addr = 2;
      run_cycle("wrap.exp");
      quiet(); creg_rd_addr = 2;
      #1 check("wrap.epc", creg_rd_data, 32'h3FFF_FFFF);
      run_cycle("wrap.rd");

      // 5: interrupt (only taken in the IRQ build)
      wrcr(5'd5, 32'hFE, "t5.mask");
      wrcr(5'd0, 32'h2, "t5.int_en");
      quiet(); mem_en = 1; irq = 8'h02; creg_rd_addr = 6;
      #1 check("t5.masked", if_flush, 1'b0);
      run_cycle("t5.masked");
      quiet(); mem_en = 1; irq = 8'h01; mem_pc = 30'h20;
      #1 check("t5.flush", if_flush, IRQ_ON);
      run_cycle("t5.irq");
      quiet(); creg_rd_addr = 4;
      run_cycle("t5.cause");

      // 6: exception held off by a busy bus commits exactly once
      for (int i = 0; i < 3; i++) begin
         quiet(); mem_en = 1; mem_busy = 1; mem_exp_code = 3'd3; mem_pc = 30'h50;
         creg_rd_addr = 2;
         #1 check("t6.held", mem_flush, 1'b0);
         run_cycle("t6.busy");
      end
      mem_busy = 0;
      #1 check("t6.flush", mem_flush, 1'b1);
      run_cycle("t6.commit");
      quiet(); creg_rd_addr = 2;
      #1 check("t6.epc", creg_rd_data, 32'h50);
      check("t6.once", mem_flush, 1'b0);
      run_cycle("t6.after");

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         reset        = ($urandom_range(0, 60) == 0);
         if_busy      = ($urandom_range(0, 4) == 0);
         mem_busy     = ($urandom_range(0, 4) == 0);
         ld_hazard    = ($urandom_range(0, 4) == 0);
         mem_en       = ($urandom_range(0, 3) != 0);
         mem_br_flag  = 1'($urandom);
         mem_pc       = 30'($urandom);
         mem_ctrl_op  = 2'($urandom);
         mem_dst_addr = 5'($urandom_range(0, 7));
         mem_out      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         mem_exp_code = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         irq          = 8'($urandom);
         creg_rd_addr = 5'($urandom_range(0, 8));
         run_cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
